// File: rtl/atomic_count_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : atomic_count_reader_if
//  Description : Snapshot consumer handshake plus atomic-counter read bus.
//                slave  = the reader block, master = its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface atomic_count_reader_if;
    logic        rd_start;
    logic        rd_busy;
    logic        rd_valid;
    logic        rd_ready;
    logic [63:0] rd_data;
    logic        rd_err;
    logic        rd_wrap;
    logic        req;
    logic        atomic;
    logic        ack;
    logic [31:0] count;

    modport slave (
        input  rd_start, rd_ready, ack, count,
        output rd_busy, rd_valid, rd_data, rd_err, rd_wrap, req, atomic
    );

    modport master (
        output rd_start, rd_ready, ack, count,
        input  rd_busy, rd_valid, rd_data, rd_err, rd_wrap, req, atomic
    );
endinterface
`default_nettype wire

// File: rtl/atomic_count_reader.sv
`default_nettype none
// ============================================================================
//  Module      : atomic_count_reader
//  Description : Reads a 64-bit counter as two 32-bit halves. The low-half
//                read freezes the high half, so {hi, lo} is coherent. Flags
//                timeouts and snapshots that went backwards (wrap).
//  Revision    : 1.0 - initial release
// ============================================================================
module atomic_count_reader #(
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    atomic_count_reader_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LO_REQ  = 3'd1,
        LO_WAIT = 3'd2,
        HI_REQ  = 3'd3,
        HI_WAIT = 3'd4,
        HOLD    = 3'd5
    } state_t;

    // Last waiting cycle index: ack here still succeeds, silence here times out.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [63:0] prev;
    logic        prev_valid;
    logic [7:0]  wait_cnt;
    logic        err;

    logic        waiting;
    logic        timeout_hit;
    logic [63:0] snap;
    logic        req_c;
    logic        atomic_c;

    assign waiting     = (state == LO_WAIT) || (state == HI_WAIT);
    assign timeout_hit = (wait_cnt == WAIT_LAST);
    assign snap        = {hi, lo};

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and request decode; ack only matters in the two wait states.
    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        atomic_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rd_start) state_nxt = LO_REQ;
            end
            LO_REQ: begin
                req_c     = 1'b1;
                atomic_c  = 1'b1;
                state_nxt = LO_WAIT;
            end
            LO_WAIT: begin
                if (bus.ack)          state_nxt = HI_REQ;
                else if (timeout_hit) state_nxt = HOLD;
            end
            HI_REQ: begin
                req_c     = 1'b1;
                state_nxt = HI_WAIT;
            end
            HI_WAIT: begin
                if (bus.ack || timeout_hit) state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.rd_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture halves, run the wait counter, track error and previous good snapshot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lo         <= 32'd0;
            hi         <= 32'd0;
            prev       <= 64'd0;
            prev_valid <= 1'b0;
            wait_cnt   <= 8'd0;
            err        <= 1'b0;
        end else begin
            // Held at zero outside the wait states, so each wait starts from 0.
            if (waiting && !bus.ack) wait_cnt <= wait_cnt + 8'd1;
            else                     wait_cnt <= 8'd0;

            if (state == LO_REQ) err <= 1'b0;
            if (waiting && !bus.ack && timeout_hit) err <= 1'b1;

            if (state == LO_WAIT && bus.ack) lo <= bus.count;
            if (state == HI_WAIT && bus.ack) hi <= bus.count;

            // Only good snapshots become the reference for wrap detection.
            if (state == HOLD && bus.rd_ready && !err) begin
                prev       <= snap;
                prev_valid <= 1'b1;
            end
        end
    end

    assign bus.req      = req_c;
    assign bus.atomic   = atomic_c;
    assign bus.rd_busy  = (state != IDLE);
    assign bus.rd_valid = (state == HOLD);
    assign bus.rd_err   = (state == HOLD) && err;
    assign bus.rd_data  = (state == HOLD && !err) ? snap : 64'd0;
    assign bus.rd_wrap  = (state == HOLD) && !err && prev_valid && (snap < prev);

endmodule
`default_nettype wire

// File: tb/tb_atomic_count_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_atomic_count_reader
//  Description : Self-checking bench: directed vector table, reset corner
//                sequences and randomized snapshots against a timing model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_atomic_count_reader;

    localparam int TIMEOUT = 15;
    localparam int LATE    = TIMEOUT + 1;   // ack arriving after the wait window

    logic clk   = 1'b0;
    logic reset = 1'b0;

    atomic_count_reader_if bus ();

    atomic_count_reader #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] prev_m       = 64'd0;
    bit          prev_valid_m = 1'b0;

    typedef struct {
        int          lo_ack;   // wait cycle (1-based) carrying the low-half ack
        int          hi_ack;   // wait cycle carrying the high-half ack
        logic [31:0] lo_val;
        logic [31:0] hi_val;
        int          rdy;      // cycles of rd_ready=0 while holding
        bit          ss;       // assert rd_start throughout HOLD
        bit          sa;       // stray ack in the req cycles
        logic        err;
        logic        wrap;
        logic [63:0] data;
        int          lat;
        int          pulses;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, ".flags"}, 64'({bus.req, bus.atomic, bus.rd_busy, bus.rd_valid,
                                   bus.rd_err, bus.rd_wrap}), 64'd0);
        chk({name, ".data"}, bus.rd_data, 64'd0);
    endtask

    // Expected outcome of one snapshot from the timing/value rules.
    function automatic void model(input int lo_ack, input int hi_ack,
                                  input logic [31:0] lo_val, input logic [31:0] hi_val,
                                  output logic err, output logic wrap,
                                  output logic [63:0] data, output int lat, output int pulses);
        wrap = 1'b0;
        data = 64'd0;
        if (lo_ack > TIMEOUT) begin
            err = 1'b1; lat = 2 + TIMEOUT; pulses = 1;
        end else if (hi_ack > TIMEOUT) begin
            err = 1'b1; lat = 3 + lo_ack + TIMEOUT; pulses = 2;
        end else begin
            err = 1'b0; lat = 3 + lo_ack + hi_ack; pulses = 2;
            data = {hi_val, lo_val};
            wrap = prev_valid_m && (data < prev_m);
        end
    endfunction

    task automatic snapshot(input string tag, input int lo_ack, input int hi_ack,
                            input logic [31:0] lo_val, input logic [31:0] hi_val,
                            input int rdy, input bit ss, input bit sa,
                            input logic e_err, input logic e_wrap, input logic [63:0] e_data,
                            input int e_lat, input int e_pulses);
        int c_lo = -1, c_hi = -1, pulses = 0, hold_cnt = 0;
        bit seen = 1'b0, done = 1'b0;
        logic [63:0] h_data;
        logic [1:0]  h_flags;
        @(negedge clk);
        chk({tag, ".idle"}, 64'(bus.rd_busy), 64'd0);
        bus.rd_start = 1'b1; bus.ack = 1'b0; bus.rd_ready = 1'b0;
        for (int n = 1; n <= 80 && !done; n++) begin
            @(negedge clk);
            if (bus.req) begin
                pulses++;
                if (c_lo < 0) begin c_lo = n; chk({tag, ".atomic_lo"}, 64'(bus.atomic), 64'd1); end
                else begin c_hi = n; chk({tag, ".atomic_hi"}, 64'(bus.atomic), 64'd0); end
            end
            bus.rd_start = 1'b0; bus.ack = 1'b0; bus.count = $urandom; bus.rd_ready = 1'b0;
            if (sa && (n == c_lo || n == c_hi)) bus.ack = 1'b1;
            if (c_lo >= 0 && c_hi < 0 && n == c_lo + lo_ack) begin bus.ack = 1'b1; bus.count = lo_val; end
            if (c_hi >= 0 && n == c_hi + hi_ack) begin bus.ack = 1'b1; bus.count = hi_val; end
            if (bus.rd_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    chk({tag, ".lat"},  64'(n), 64'(e_lat));
                    chk({tag, ".data"}, bus.rd_data, e_data);
                    chk({tag, ".err"},  64'(bus.rd_err), 64'(e_err));
                    chk({tag, ".wrap"}, 64'(bus.rd_wrap), 64'(e_wrap));
                    h_data = bus.rd_data; h_flags = {bus.rd_err, bus.rd_wrap};
                end else begin
                    chk({tag, ".hold_data"},  bus.rd_data, h_data);
                    chk({tag, ".hold_flags"}, 64'({bus.rd_err, bus.rd_wrap}), 64'(h_flags));
                end
                bus.rd_start = ss;
                if (hold_cnt == rdy) begin bus.rd_ready = 1'b1; done = 1'b1; end
                hold_cnt++;
            end else if (bus.rd_data != 64'd0) begin
                chk({tag, ".data_outside_hold"}, bus.rd_data, 64'd0);
            end
        end
        if (!done) chk({tag, ".no_valid_within_budget"}, 64'd0, 64'd1);
        @(negedge clk);
        bus.rd_start = 1'b0; bus.rd_ready = 1'b0; bus.ack = 1'b0;
        chk_quiet({tag, ".after_hs"});
        @(negedge clk);
        chk({tag, ".no_extra"}, 64'({bus.rd_busy, bus.req}), 64'd0);
        chk({tag, ".pulses"}, 64'(pulses), 64'(e_pulses));
        if (!e_err) begin prev_m = e_data; prev_valid_m = 1'b1; end
    endtask

    // Abandon a snapshot by reset `at` cycles after rd_start, then send a late ack.
    task automatic reset_mid(input string tag, input int at);
        @(negedge clk);
        bus.rd_start = 1'b1;
        for (int n = 1; n <= at; n++) begin
            @(negedge clk);
            bus.rd_start = 1'b0;
        end
        chk({tag, ".busy_before"}, 64'(bus.rd_busy), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk_quiet({tag, ".in_reset"});
        reset = 1'b1; bus.ack = 1'b1; bus.count = 32'h5A5A_5A5A;
        @(negedge clk);
        bus.ack = 1'b0;
        chk_quiet({tag, ".late_ack"});
        @(negedge clk);
        chk_quiet({tag, ".settled"});
        prev_m = 64'd0; prev_valid_m = 1'b0;
    endtask

    initial begin
        logic        e_err, e_wrap;
        logic [63:0] e_data;
        int          e_lat, e_pul, la, ha, rdy;
        logic [31:0] lv, hv;

        vecs[0] = '{1, 1, 32'h5, 32'h1, 0, 0, 0, 0, 0, 64'h0000_0001_0000_0005, 5, 2};
        vecs[1] = '{1, 1, 32'h6, 32'h1, 10, 0, 1, 0, 0, 64'h0000_0001_0000_0006, 5, 2};
        vecs[2] = '{1, LATE, 32'h9, 32'h9, 0, 0, 0, 1, 0, 64'h0, 19, 2};
        vecs[3] = '{2, 15, 32'h7, 32'h1, 1, 1, 0, 0, 0, 64'h0000_0001_0000_0007, 20, 2};
        vecs[4] = '{LATE, 1, 32'h0, 32'h0, 2, 1, 1, 1, 0, 64'h0, 17, 1};
        vecs[5] = '{3, 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 7, 2};
        vecs[6] = '{1, LATE, 32'h0, 32'h0, 0, 0, 0, 1, 0, 64'h0, 19, 2};
        vecs[7] = '{1, 1, 32'h3, 32'h0, 1, 1, 0, 0, 1, 64'h3, 5, 2};
        vecs[8] = '{2, 2, 32'h3, 32'h0, 0, 0, 1, 0, 0, 64'h3, 7, 2};
        vecs[9] = '{15, 1, 32'h2, 32'h0, 0, 0, 0, 0, 1, 64'h2, 19, 2};

        bus.rd_start = 1'b0; bus.rd_ready = 1'b0; bus.ack = 1'b0; bus.count = 32'd0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        reset = 1'b1;

        // Stray acks while idle must not start anything.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.ack = 1'b1; bus.count = $urandom;
            chk("idle_ack", 64'({bus.rd_busy, bus.req}), 64'd0);
        end
        @(negedge clk);
        bus.ack = 1'b0;
        chk("idle_ack_end", 64'({bus.rd_busy, bus.req}), 64'd0);

        for (int i = 0; i < 10; i++)
            snapshot($sformatf("vec%0d", i), vecs[i].lo_ack, vecs[i].hi_ack, vecs[i].lo_val,
                     vecs[i].hi_val, vecs[i].rdy, vecs[i].ss, vecs[i].sa, vecs[i].err,
                     vecs[i].wrap, vecs[i].data, vecs[i].lat, vecs[i].pulses);

        reset_mid("rst_after_req", 1);
        reset_mid("rst_lo_wait", 2);
        // prev was cleared, so a smaller value is not a wrap.
        snapshot("post_reset", 1, 1, 32'h1, 32'h0, 0, 0, 0, 0, 0, 64'h1, 5, 2);

        for (int i = 0; i < 40; i++) begin
            la  = ($urandom_range(0, 7) == 0) ? LATE : int'($urandom_range(1, TIMEOUT));
            ha  = ($urandom_range(0, 7) == 0) ? LATE : int'($urandom_range(1, TIMEOUT));
            lv  = $urandom;
            hv  = $urandom_range(0, 3);
            rdy = $urandom_range(0, 3);
            model(la, ha, lv, hv, e_err, e_wrap, e_data, e_lat, e_pul);
            snapshot($sformatf("rnd%0d", i), la, ha, lv, hv, rdy, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), e_err, e_wrap, e_data, e_lat, e_pul);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                bus.ack = 1'($urandom_range(0, 1)); bus.count = $urandom;
                chk($sformatf("rnd%0d.gap", i), 64'({bus.rd_busy, bus.req}), 64'd0);
            end
            bus.ack = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/atomic_count_reader.md
ATOMIC_COUNT_READER -- requirements
Module: atomic_count_reader

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles to wait for ack per half-read (legal 1..255).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset  input  1  reset, synchronous and active-low.
REQ-004 rd_start  input  1  request one 64-bit snapshot; sampled only in IDLE.
REQ-005 rd_busy  output  1  high in every state except IDLE.
REQ-006 rd_valid  output  1  snapshot available on rd_data.
REQ-007 rd_ready  input  1  consumer accepts snapshot when rd_valid && rd_ready.
REQ-008 rd_data  output  64  assembled snapshot {hi, lo}.
REQ-009 rd_err  output  1  qualifies rd_valid; snapshot aborted by timeout.
REQ-010 rd_wrap  output  1  qualifies rd_valid; snapshot below previous good snapshot.
REQ-011 req  output  1  read request pulse to the atomic counter.
REQ-012 atomic  output  1  qualifies req: 1 = low-half read that freezes the high half, 0 = read of the frozen high half.
REQ-013 ack  input  1  counter response; count is valid in the same cycle.
REQ-014 count  input  32  counter read data.

Function
REQ-015 The FSM SHALL have states IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT and HOLD.
REQ-016 IDLE -> LO_REQ on rd_start=1; otherwise hold.
REQ-017 LO_REQ SHALL last exactly one cycle, drive req=1 and atomic=1, then go to LO_WAIT.
REQ-018 In LO_WAIT, ack=1 SHALL capture count into lo and go to HI_REQ.
REQ-019 HI_REQ SHALL last exactly one cycle, drive req=1 and atomic=0, then go to HI_WAIT.
REQ-020 In HI_WAIT, ack=1 SHALL capture count into hi and go to HOLD with rd_err=0.
REQ-021 req and atomic SHALL be 0 in all states other than LO_REQ and HI_REQ; each snapshot issues exactly two req pulses.
REQ-022 ack SHALL be ignored in IDLE, LO_REQ, HI_REQ and HOLD; no data is captured and no state changes as a result.
REQ-023 Timeout: an 8-bit wait counter SHALL clear on entry to LO_WAIT or HI_WAIT and increment each waiting cycle without ack.
REQ-024 If the wait counter reaches TIMEOUT without ack, the FSM SHALL go to HOLD with rd_err=1 and rd_data=0.
REQ-025 ack in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-026 In HOLD, rd_valid=1 and rd_data, rd_err and rd_wrap SHALL stay stable until rd_ready=1.
REQ-027 On the HOLD handshake the FSM SHALL return to IDLE; rd_start in that same cycle SHALL be ignored, so a new snapshot needs rd_start in IDLE.
REQ-028 The minimum snapshot latency with 1-cycle ack is 5 cycles from the rd_start cycle to rd_valid=1.
REQ-029 A 64-bit prev register SHALL hold the last snapshot delivered with rd_err=0 and SHALL update at its handshake.
REQ-030 rd_wrap SHALL equal 1 when rd_err=0, a previous good snapshot exists, and {hi, lo} < prev, using an unsigned 64-bit compare.
REQ-031 rd_wrap SHALL equal 0 for an error snapshot and for the first good snapshot after reset.
REQ-032 A first-snapshot flag SHALL track whether prev is valid.
REQ-033 Error snapshots SHALL NOT update prev.
REQ-034 rd_valid SHALL be 0 outside HOLD, and rd_data SHALL be 0 outside HOLD.

Reset
REQ-035 While reset=0 at a clock edge, the FSM SHALL enter IDLE.
REQ-036 Reset SHALL clear lo, hi, prev, the wait counter and the first-snapshot flag.
REQ-037 After the reset edge, req, atomic, rd_busy, rd_valid, rd_err, rd_wrap and rd_data SHALL all be 0.
REQ-038 Reset mid-snapshot, including the cycle after a req pulse, SHALL abandon the snapshot with no output.
REQ-039 A late ack arriving after reset SHALL be ignored per REQ-022.

Verification
REQ-040 Basic read: rd_start; ack one cycle after each req, with count 0x0000_0005 then 0x0000_0001 -> rd_valid with rd_data=0x0000_0001_0000_0005, rd_err=0, rd_wrap=0, 5 cycles after rd_start.
REQ-041 Backpressure: hold rd_ready=0 for 10 cycles -> rd_valid and rd_data stable throughout, exactly two req pulses total, return to IDLE the cycle after rd_ready=1.
REQ-042 Timeout: TIMEOUT=15, no ack after the high-half req -> rd_valid with rd_err=1 and rd_data=0, 15 cycles after entering HI_WAIT.
REQ-043 Timeout boundary: ack on the 15th wait cycle -> success per REQ-025.
REQ-044 Wrap: first snapshot 0xFFFF_FFFF_FFFF_FFF0, second snapshot 0x0000_0000_0000_0003 -> second has rd_wrap=1; an intervening error snapshot leaves prev unchanged.
REQ-045 Reset mid-op: reset=0 in LO_WAIT, then ack=1 after release -> IDLE, no capture, all outputs 0, next snapshot's rd_wrap=0.
REQ-046 Stray activity: ack pulses in IDLE, and rd_start asserted during HOLD -> no req, no state change, and no extra snapshot after the handshake.
